// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_pkg
//  Description : Shared defaults and helpers for the programmable sync FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    // Width needed to hold an occupancy value in the range 0..depth inclusive.
    function automatic int cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_dpram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_dpram
//  Description : Simple dual-port RAM, one write port, one registered read
//                port. Read-before-write on an address collision.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_dpram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port: storage is never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port; returns the pre-write contents on a collision.
    always_ff @(posedge clk) begin
        rdata <= r_mem[raddr];
    end

endmodule : fifo_dpram
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_prog
//  Description : Single-clock FIFO with programmable almost-full/almost-empty
//                levels, occupancy count and sticky overflow/underflow flags.
//                Define FIFO_FWFT_EN for first-word fall-through output;
//                otherwise reads have one cycle of latency.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int CW         = cw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  write,
    input  logic                  read,
    input  logic [CW-1:0]         af_level,
    input  logic [CW-1:0]         ae_level,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  alf,
    output logic                  ale,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_next;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_alf;
    logic                  r_ale;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_ram_we;
    logic                  w_ram_pop;
    logic [AW-1:0]         w_raddr;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Accept rules: a write into a full FIFO is allowed only alongside a read.
    assign w_wr_ok      = write & (~r_full | read);
    assign w_rd_ok      = read & ~r_empty;
    assign w_count_next = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);

    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (r_wr_ptr),
        .wdata (din),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    // RAM pointers; AW-bit counters wrap from DEPTH-1 back to 0 on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_ram_we) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_ram_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy and status flags, all derived from the next count so they
    // line up with count; thresholds are taken live at each edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_alf   <= (af_level == '0);
            r_ale   <= 1'b1;
        end else begin
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == DEPTH_C);
            r_alf   <= (w_count_next >= af_level);
            r_ale   <= (w_count_next <= ae_level);
        end
    end

    // Sticky error flags; a new error in the clear cycle wins over clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (write & ~w_wr_ok) | (r_ovf & ~clr_err);
            r_udf <= (read  & ~w_rd_ok) | (r_udf & ~clr_err);
        end
    end

`ifdef FIFO_FWFT_EN
    // The head entry lives in r_head; the RAM holds everything behind it.
    logic [CW-1:0]         w_mem_cnt;
    logic [CW-1:0]         w_mem_cnt_next;
    logic                  w_to_head;
    logic [DATA_WIDTH-1:0] w_ram_head;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic                  r_fresh;

    assign w_mem_cnt = r_count - CW'(~r_empty);

    // A pop refills the head from RAM when RAM has data; otherwise a write
    // that finds the head free (or being vacated) goes straight into it.
    assign w_ram_pop      = w_rd_ok & (w_mem_cnt != '0);
    assign w_to_head      = w_wr_ok & (r_empty | (w_rd_ok & (w_mem_cnt == '0)));
    assign w_ram_we       = w_wr_ok & ~w_to_head;
    assign w_mem_cnt_next = w_mem_cnt + CW'(w_ram_we) - CW'(w_ram_pop);

    // Look ahead one pointer step so rdata always shows the current RAM head.
    assign w_raddr = r_rd_ptr + AW'(w_ram_pop);

    // If the RAM head was written on the same edge it was looked up, rdata is
    // stale; the captured write data stands in for it for that one cycle.
    assign w_ram_head = r_fresh ? r_wdata_q : w_rdata;

    // Head holding register plus the stale-read bypass bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head    <= '0;
            r_wdata_q <= '0;
            r_fresh   <= 1'b0;
        end else begin
            r_fresh <= w_ram_we & (w_mem_cnt_next == CW'(1));
            if (w_ram_we) begin
                r_wdata_q <= din;
            end
            if (w_ram_pop) begin
                r_head <= w_ram_head;
            end else if (w_to_head) begin
                r_head <= din;
            end
        end
    end

    assign dout = r_head;
`else
    // Standard mode: the RAM read register is the data path; a hold register
    // keeps the last read word once rdata moves on.
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_dout_q;

    assign w_ram_we  = w_wr_ok;
    assign w_ram_pop = w_rd_ok;
    assign w_raddr   = r_rd_ptr;

    // Track which cycle carries fresh read data and retain it afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_dout_q   <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (r_rd_valid) begin
                r_dout_q <= w_rdata;
            end
        end
    end

    assign dout = r_rd_valid ? w_rdata : r_dout_q;
`endif

    assign count     = r_count;
    assign empty     = r_empty;
    assign full      = r_full;
    assign alf       = r_alf;
    assign ale       = r_ale;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule : sync_fifo_prog
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_prog
//  Description : Self-checking bench for sync_fifo_prog against a queue model.
//                Honours FIFO_FWFT_EN for the expected dout behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          write;
    logic          read;
    logic [CW-1:0] af_level;
    logic [CW-1:0] ae_level;
    logic          clr_err;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic          alf;
    logic          ale;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    sync_fifo_prog #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .write     (write),
        .read      (read),
        .af_level  (af_level),
        .ae_level  (ae_level),
        .clr_err   (clr_err),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .alf       (alf),
        .ale       (ale),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus last popped word and flags.
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_last;
    bit            m_ovf;
    bit            m_udf;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later.
    task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d,
                         input bit clr, input bit rst, input string tag);
        bit            m_full;
        bit            m_empty;
        bit            wr_ok;
        bit            rd_ok;
        logic [DW-1:0] exp_dout;
        write   = w;
        read    = r;
        din     = d;
        clr_err = clr;
        reset   = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_last = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            wr_ok   = w && (!m_full || r);
            rd_ok   = r && !m_empty;
            if (rd_ok) m_last = q.pop_front();
            if (wr_ok) q.push_back(d);
            m_ovf = (w && !wr_ok) || (m_ovf && !clr);
            m_udf = (r && !rd_ok) || (m_udf && !clr);
        end
        #1;
`ifdef FIFO_FWFT_EN
        exp_dout = (q.size() > 0) ? q[0] : m_last;
`else
        exp_dout = m_last;
`endif
        chk({tag, ".count"},     32'(count),     32'(q.size()));
        chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
        chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
        chk({tag, ".alf"},       32'(alf),       32'(q.size() >= int'(af_level)));
        chk({tag, ".ale"},       32'(ale),       32'(q.size() <= int'(ae_level)));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".dout"},      32'(dout),      32'(exp_dout));
    endtask

    initial begin
        af_level = CW'(12);
        ae_level = CW'(3);
        write = 1'b0; read = 1'b0; din = '0; clr_err = 1'b0; reset = 1'b1;

        // Reset state
        cycle(0, 0, 8'h00, 0, 1, "rst0");
        cycle(0, 0, 8'h00, 0, 1, "rst1");
        chk("rst.empty_const", 32'(empty), 32'd1);
        chk("rst.dout_const",  32'(dout),  32'd0);

        // 1: fill with 0x00..0x0F, then one write too many
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, DW'(i), 0, 0, "fill");
        chk("fill.full_const", 32'(full), 32'd1);
        cycle(1, 0, 8'hEE, 0, 0, "ovf");
        chk("ovf.flag_const",  32'(overflow), 32'd1);
        chk("ovf.count_const", 32'(count),    32'd16);
        cycle(0, 0, 8'h00, 1, 0, "clr1");

        // 2: drain in order, then one read too many
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00, 0, 0, "drain");
        cycle(0, 1, 8'h00, 0, 0, "udf");
        chk("udf.flag_const", 32'(underflow), 32'd1);
        chk("udf.dout_hold",  32'(dout),      32'h0F);
        cycle(0, 0, 8'h00, 1, 0, "clr2");

        // 3: full FIFO, simultaneous write+read; 0xAA emerges after wrap
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, DW'($urandom), 0, 0, "refill");
        cycle(1, 1, 8'hAA, 0, 0, "fullwr");
        chk("fullwr.count_const", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00, 0, 0, "wrapread");
`ifndef FIFO_FWFT_EN
        chk("wrap.aa_out", 32'(dout), 32'hAA);
`endif

        // 4: empty FIFO, simultaneous write+read: only the write lands
        cycle(1, 1, 8'h55, 0, 0, "emptywr");
        chk("emptywr.count_const", 32'(count), 32'd1);
        cycle(0, 1, 8'h00, 1, 0, "clrsame");
        cycle(0, 1, 8'h00, 1, 0, "clr_newerr");
        cycle(0, 0, 8'h00, 1, 0, "clr4");

        // 5: partial fill then reset discards the data
        for (int i = 0; i < 5; i++) cycle(1, 0, DW'(8'h90 + i), 0, 0, "fill5");
        cycle(0, 0, 8'h00, 0, 1, "midrst");
        chk("midrst.count_const", 32'(count), 32'd0);
        cycle(1, 0, 8'h77, 0, 0, "postrst_wr");
        cycle(0, 1, 8'h00, 0, 0, "postrst_rd");
        chk("postrst.dout_new", 32'(dout), 32'h77);

`ifdef FIFO_FWFT_EN
        // 6: fall-through of a single word
        cycle(1, 0, 8'h3C, 0, 0, "fwft_wr");
        chk("fwft.dout_const",  32'(dout),  32'h3C);
        chk("fwft.empty_const", 32'(empty), 32'd0);
        cycle(0, 1, 8'h00, 0, 0, "fwft_rd");
        chk("fwft.empty_after", 32'(empty), 32'd1);
`endif

        // Random traffic with live threshold changes and occasional clears
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) af_level = CW'($urandom_range(0, DEPTH));
            if ($urandom_range(0, 15) == 0) ae_level = CW'($urandom_range(0, DEPTH));
            cycle(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45),
                  DW'($urandom), bit'($urandom_range(0, 9) == 0),
                  bit'($urandom_range(0, 199) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sync_fifo_prog
`default_nettype wire
